// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage producing ALU op/operand slots behind a
// valid/ready handshake with an output register and one skid entry.
module alu_issue_stage #(
  parameter int unsigned XLEN       = 32,
  parameter logic [3:0]  ILLEGAL_OP = 4'b0011
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      Alu_op,
  output logic [XLEN-1:0] data_01,
  output logic [XLEN-1:0] data_02,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            illegal,
  output logic [XLEN-1:0] out_pc
);

  typedef enum logic [3:0] {
    OP_SLL  = 4'b0000,
    OP_SRL  = 4'b0001,
    OP_SRA  = 4'b0010,
    OP_ADD  = 4'b0011,
    OP_SUB  = 4'b0100,
    OP_OR   = 4'b0101,
    OP_AND  = 4'b0110,
    OP_XOR  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_LUI  = 4'b1010
  } alu_op_e;

  typedef struct packed {
    logic [3:0]      alu_op;
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
    logic [4:0]      rd;
    logic            rw;
    logic            ill;
    logic [XLEN-1:0] pc;
  } slot_t;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    unique case (f3)
      3'b000:  op = alt ? OP_SUB : OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = alt ? OP_SRA : OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_shamt;
  logic            w_legal;
  alu_op_e         w_op;
  logic [XLEN-1:0] w_d1;
  logic [XLEN-1:0] w_d2;
  slot_t           w_dec;

  assign w_opc    = in_instr[6:0];
  assign w_f3     = in_instr[14:12];
  assign w_f7     = in_instr[31:25];
  assign w_imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_u  = {in_instr[31:12], 12'b0};
  assign w_shamt  = {27'b0, in_instr[24:20]};
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  always_comb begin
    w_legal = 1'b0;
    w_op    = OP_ADD;
    w_d1    = '0;
    w_d2    = '0;
    unique case (w_opc)
      OPC_OP: begin
        w_legal = (w_f7 == F7_ZERO) ||
                  ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
        w_op    = f3_to_op(w_f3, w_f7[5]);
        w_d1    = rs1_data;
        w_d2    = rs2_data;
      end
      OPC_OPIMM: begin
        w_d1 = rs1_data;
        if (w_f3 == 3'b001) begin
          w_legal = (w_f7 == F7_ZERO);
          w_op    = OP_SLL;
          w_d2    = w_shamt;
        end else if (w_f3 == 3'b101) begin
          w_legal = (w_f7 == F7_ZERO) || (w_f7 == F7_ALT);
          w_op    = w_f7[5] ? OP_SRA : OP_SRL;
          w_d2    = w_shamt;
        end else begin
          // funct3 000 is ADDI regardless of imm bit 30
          w_legal = 1'b1;
          w_op    = f3_to_op(w_f3, 1'b0);
          w_d2    = w_imm_i;
        end
      end
      OPC_LUI: begin
        w_legal = 1'b1;
        w_op    = OP_LUI;
        w_d2    = w_imm_u;
      end
      OPC_AUIPC: begin
        w_legal = 1'b1;
        w_op    = OP_ADD;
        w_d1    = in_pc;
        w_d2    = w_imm_u;
      end
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_dec     = '0;
    w_dec.rd  = in_instr[11:7];
    w_dec.pc  = in_pc;
    w_dec.ill = !w_legal;
    if (w_legal) begin
      w_dec.alu_op = w_op;
      w_dec.d1     = w_d1;
      w_dec.d2     = w_d2;
      w_dec.rw     = (in_instr[11:7] != 5'd0);
    end else begin
      w_dec.alu_op = ILLEGAL_OP;
    end
  end

  slot_t r_out;
  slot_t r_skid;
  logic  r_out_valid;
  logic  r_skid_valid;
  logic  w_accept;
  logic  w_out_free;

  assign w_accept   = in_valid && !r_skid_valid;
  assign w_out_free = !r_out_valid || out_ready;

  // When the output frees up, a held skid entry takes priority; in_ready is
  // low in that cycle so no new accept can compete with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out        <= '0;
      r_out.alu_op <= OP_ADD;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out       <= w_dec;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end

  assign in_ready  = !r_skid_valid;
  assign out_valid = r_out_valid;
  assign Alu_op    = r_out.alu_op;
  assign data_01   = r_out.d1;
  assign data_02   = r_out.d2;
  assign rd        = r_out.rd;
  assign reg_write = r_out.rw;
  assign illegal   = r_out.ill;
  assign out_pc    = r_out.pc;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Decode/issue stage on the producing side of the ALU operation interface. It accepts RV32I integer instructions, reads register operands, and generates Alu_op, data_01 and data_02 in the ALU's encoding. Results are registered behind a valid/ready handshake with a one-entry skid buffer, so the ALU/execute stage can stall without dropping instructions.

Parameters:
XLEN, 32, operand/instruction width (only 32 supported)
ILLEGAL_OP, 4'b0011, Alu_op driven for illegal instructions (ADD)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous flush: drop all held/accepted instructions
in_valid  input  1  instruction valid
in_ready  output  1  stage can accept instruction
in_instr  input  32  instruction word
in_pc  input  32  instruction PC
rs1_addr  output  5  combinational in_instr[19:15] to register file
rs2_addr  output  5  combinational in_instr[24:20] to register file
rs1_data  input  32  register file read data, same cycle as in_instr
rs2_data  input  32  register file read data, same cycle as in_instr
out_valid  output  1  issue slot valid
out_ready  input  1  execute stage accepts slot
Alu_op  output  4  ALU operation code
data_01  output  32  first ALU operand
data_02  output  32  second ALU operand (rs2 or immediate)
rd  output  5  destination register
reg_write  output  1  write rd with ALU result
illegal  output  1  instruction not decodable by this stage
out_pc  output  32  PC of issued instruction

Behaviour:
- Alu_op codes: 0000 SLL, 0001 SRL, 0010 SRA, 0011 ADD, 0100 SUB, 0101 OR, 0110 AND, 0111 XOR, 1000 SLT, 1001 SLTU, 1010 LUI (pass data_02).
- OP (0110011): funct7 must be 0000000, except 0100000 with funct3 000 (SUB) or 101 (SRA). funct3 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND. data_01=rs1_data, data_02=rs2_data. Any other funct7 is illegal.
- OP-IMM (0010011): data_01=rs1_data, data_02=sign-extended instr[31:20]. funct3 map as OP; 000 is always ADD. For shifts (001 SLLI, 101 SRLI/SRAI), data_02={27'b0, instr[24:20]}. instr[31:25] must be 0000000, or 0100000 for SRAI only; otherwise illegal.
- LUI (0110111): Alu_op 1010, data_01=0, data_02={instr[31:12],12'b0}.
- AUIPC (0010111): Alu_op 0011, data_01=in_pc, data_02={instr[31:12],12'b0}.
- Other opcodes: illegal=1, Alu_op=ILLEGAL_OP, data_01=data_02=0, reg_write=0.
- reg_write=1 for legal instructions with rd!=0. rd=instr[11:7] always.
- Handshake: accept when in_valid&&in_ready. Latency 1 cycle: the decoded slot appears on outputs the cycle after acceptance. Throughput is 1 per cycle when out_ready is held high.
- Storage: output register plus one skid entry. in_ready = !skid_valid, registered (no combinational path from out_ready).
- Output register holds its contents while out_valid&&!out_ready.
- An accept while the output is stalled goes to the skid entry. When out_ready drains the output, the skid entry moves into the output register in that same edge. Simultaneous drain and accept with an empty skid loads the output directly.
- Ordering is strictly FIFO; no slot is ever dropped or duplicated except by flush/reset.
- flush: next edge clears out_valid and skid_valid and ignores any same-cycle accept. in_ready=1 the following cycle. Datapath outputs may retain stale values.
- Reset (async assert, sync-safe deassert): out_valid=0, skid empty, in_ready=1, Alu_op=0011, data_01=data_02=0, rd=0, reg_write=0, illegal=0, out_pc=0. Reset mid-stall discards all held slots.
- Registered outputs are stable while out_valid&&!out_ready (checked by assertion).

Test Plan:
- add x3,x1,x2 (0x002081B3), rs1_data=5, rs2_data=7, out_ready=1 -> next cycle out_valid=1, Alu_op=0011, data_01=5, data_02=7, rd=3, reg_write=1.
- srai x5,x6,4 (0x40435293), rs1_data=0x80000000 -> Alu_op=0010, data_02=4, rd=5. addi x2,x0,-1 (0xFFF00113) -> Alu_op=0011, data_02=0xFFFFFFFF.
- lui x1,0x12345 (0x123450B7) -> Alu_op=1010, data_01=0, data_02=0x12345000. auipc x1,1 with in_pc=0x100 -> Alu_op=0011, data_01=0x100, data_02=0x1000.
- Illegal 0xFFFFFFFF, and add with funct7=0000001 -> illegal=1, Alu_op=0011, reg_write=0. add x0,x1,x2 -> reg_write=0, illegal=0.
- Back-to-back stream of 3 instructions with out_ready low for 2 cycles -> in_ready drops after the 2nd accept, no loss, issue order 1,2,3 preserved, outputs stable while stalled.
- flush with both entries full plus in_valid -> next cycle out_valid=0, in_ready=1. rst_n pulsed mid-stream -> all outputs at reset values immediately.
